// File: rtl/axi4_lite_mem_responder_if.sv
// AXI4-Lite bus bundle between a requester (master) and the memory responder (slave).
// Valid/ready rule on every channel: a transfer happens on the rising edge where both
// valid and ready are high; a source holds valid and its payload stable until that edge.
interface axi4_lite_mem_responder_if #(
  parameter int addr_width_p = 28,
  parameter int data_width_p = 64
);
  logic [addr_width_p-1:0]   awaddr_i;
  logic [2:0]                awprot_i;
  logic                      awvalid_i;
  logic                      awready_o;
  logic [data_width_p-1:0]   wdata_i;
  logic [data_width_p/8-1:0] wstrb_i;
  logic                      wvalid_i;
  logic                      wready_o;
  logic [1:0]                bresp_o;
  logic                      bvalid_o;
  logic                      bready_i;
  logic [addr_width_p-1:0]   araddr_i;
  logic [2:0]                arprot_i;
  logic                      arvalid_i;
  logic                      arready_o;
  logic [data_width_p-1:0]   rdata_o;
  logic [1:0]                rresp_o;
  logic                      rvalid_o;
  logic                      rready_i;

  modport slave (
    input  awaddr_i, awprot_i, awvalid_i, wdata_i, wstrb_i, wvalid_i, bready_i,
    input  araddr_i, arprot_i, arvalid_i, rready_i,
    output awready_o, wready_o, bresp_o, bvalid_o, arready_o, rdata_o, rresp_o, rvalid_o
  );

  modport master (
    output awaddr_i, awprot_i, awvalid_i, wdata_i, wstrb_i, wvalid_i, bready_i,
    output araddr_i, arprot_i, arvalid_i, rready_i,
    input  awready_o, wready_o, bresp_o, bvalid_o, arready_o, rdata_o, rresp_o, rvalid_o
  );
endinterface

// File: rtl/axi4_lite_mem_responder.sv
// AXI4-Lite responder over a word memory: one outstanding write and one outstanding read,
// byte strobes, DECERR for word indices beyond the memory depth.
module axi4_lite_mem_responder #(
  parameter int addr_width_p = 28,
  parameter int data_width_p = 64,
  parameter int els_p        = 1024
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  axi4_lite_mem_responder_if.slave     bus
);
  localparam int strb_w_lp = data_width_p / 8;
  localparam int off_w_lp  = $clog2(strb_w_lp);
  localparam int idx_w_lp  = addr_width_p - off_w_lp;
  localparam int mem_aw_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam logic [1:0] resp_okay_lp   = 2'b00;
  localparam logic [1:0] resp_decerr_lp = 2'b11;

  logic                    aw_full_q, aw_full_d;
  logic [addr_width_p-1:0] awaddr_q, awaddr_d;
  logic                    w_full_q, w_full_d;
  logic [data_width_p-1:0] wdata_q, wdata_d;
  logic [strb_w_lp-1:0]    wstrb_q, wstrb_d;
  logic                    bvalid_q, bvalid_d;
  logic [1:0]              bresp_q, bresp_d;
  logic                    rvalid_q, rvalid_d;
  logic [data_width_p-1:0] rdata_q, rdata_d;
  logic [1:0]              rresp_q, rresp_d;

  logic [data_width_p-1:0] mem_q [els_p];

  logic                    aw_hs, w_hs, ar_hs, wr_commit;
  logic [addr_width_p-1:0] wr_addr, rd_addr;
  logic [data_width_p-1:0] wr_data;
  logic [strb_w_lp-1:0]    wr_strb;
  logic [idx_w_lp-1:0]     wr_idx, rd_idx;
  logic [mem_aw_lp-1:0]    wr_widx, rd_widx;
  logic                    wr_ok, rd_ok;
  logic                    unused_bits;

  assign bus.awready_o = ~aw_full_q & ~bvalid_q;
  assign bus.wready_o  = ~w_full_q & ~bvalid_q;
  assign bus.arready_o = ~rvalid_q;
  assign bus.bvalid_o  = bvalid_q;
  assign bus.bresp_o   = bresp_q;
  assign bus.rvalid_o  = rvalid_q;
  assign bus.rdata_o   = rdata_q;
  assign bus.rresp_o   = rresp_q;

  assign aw_hs = bus.awvalid_i & bus.awready_o;
  assign w_hs  = bus.wvalid_i & bus.wready_o;
  assign ar_hs = bus.arvalid_i & bus.arready_o;

  // The write commits as soon as both halves are available; a payload handshaking
  // this cycle is used directly rather than waiting a cycle in its holding register.
  assign wr_commit = (aw_full_q | aw_hs) & (w_full_q | w_hs);
  assign wr_addr   = aw_full_q ? awaddr_q : bus.awaddr_i;
  assign wr_data   = w_full_q ? wdata_q : bus.wdata_i;
  assign wr_strb   = w_full_q ? wstrb_q : bus.wstrb_i;
  assign rd_addr   = bus.araddr_i;

  assign wr_idx  = wr_addr[addr_width_p-1:off_w_lp];
  assign rd_idx  = rd_addr[addr_width_p-1:off_w_lp];
  assign wr_widx = wr_idx[mem_aw_lp-1:0];
  assign rd_widx = rd_idx[mem_aw_lp-1:0];
  assign wr_ok   = 64'(wr_idx) < 64'(els_p);
  assign rd_ok   = 64'(rd_idx) < 64'(els_p);

  assign unused_bits = ^{bus.awprot_i, bus.arprot_i,
                         wr_addr[off_w_lp-1:0], rd_addr[off_w_lp-1:0]};

  always_comb begin
    aw_full_d = aw_full_q;
    awaddr_d  = awaddr_q;
    w_full_d  = w_full_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;

    if (wr_commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_ok ? resp_okay_lp : resp_decerr_lp;
    end else begin
      if (aw_hs) begin
        aw_full_d = 1'b1;
        awaddr_d  = bus.awaddr_i;
      end
      if (w_hs) begin
        w_full_d = 1'b1;
        wdata_d  = bus.wdata_i;
        wstrb_d  = bus.wstrb_i;
      end
    end
    if (bvalid_q && bus.bready_i) bvalid_d = 1'b0;

    // Memory is read before this edge's write lands, giving read-before-write on collision.
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_ok ? mem_q[rd_widx] : '0;
      rresp_d  = rd_ok ? resp_okay_lp : resp_decerr_lp;
    end else if (rvalid_q && bus.rready_i) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      aw_full_q <= 1'b0;
      awaddr_q  <= '0;
      w_full_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
    end else begin
      aw_full_q <= aw_full_d;
      awaddr_q  <= awaddr_d;
      w_full_q  <= w_full_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // Memory has no reset; writes are blocked while reset is held.
  always_ff @(posedge clk_i) begin
    if (reset_n_i && wr_commit && wr_ok) begin
      for (int b = 0; b < strb_w_lp; b++) begin
        if (wr_strb[b]) mem_q[wr_widx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_axi4_lite_mem_responder.sv
// Self-checking bench for axi4_lite_mem_responder: directed scenarios plus randomized traffic
// checked against a byte-level memory model with per-byte "known" tracking.
module tb_axi4_lite_mem_responder;
  localparam int AW = 28;
  localparam int DW = 64;
  localparam int SW = DW / 8;
  localparam int ELS = 1024;
  localparam int TMO = 50;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  logic [DW-1:0] exp_q[$];
  logic [1:0]    exp_resp_q[$];
  logic [DW-1:0] ref_mem [ELS];
  logic [SW-1:0] ref_known [ELS];

  axi4_lite_mem_responder_if #(.addr_width_p(AW), .data_width_p(DW)) bus ();

  axi4_lite_mem_responder #(.addr_width_p(AW), .data_width_p(DW), .els_p(ELS)) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .bus       (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic int idx_of(logic [AW-1:0] a);
    return int'(a[AW-1:3]);
  endfunction

  function automatic logic [1:0] ref_resp(logic [AW-1:0] a);
    return (idx_of(a) < ELS) ? 2'b00 : 2'b11;
  endfunction

  task automatic ref_write(logic [AW-1:0] a, logic [DW-1:0] d, logic [SW-1:0] s);
    int i;
    i = idx_of(a);
    if (i < ELS) begin
      for (int b = 0; b < SW; b++) begin
        if (s[b]) begin
          ref_mem[i][8*b +: 8] = d[8*b +: 8];
          ref_known[i][b] = 1'b1;
        end
      end
    end
  endtask

  function automatic logic [DW-1:0] ref_mask(logic [AW-1:0] a);
    logic [DW-1:0] m;
    int i;
    i = idx_of(a);
    m = '1;
    if (i < ELS) begin
      for (int b = 0; b < SW; b++) m[8*b +: 8] = {8{ref_known[i][b]}};
    end
    return m;
  endfunction

  function automatic logic [DW-1:0] ref_data(logic [AW-1:0] a);
    int i;
    i = idx_of(a);
    return (i < ELS) ? ref_mem[i] : '0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_bus();
    bus.awaddr_i = '0; bus.awprot_i = '0; bus.awvalid_i = 1'b0;
    bus.wdata_i = '0; bus.wstrb_i = '0; bus.wvalid_i = 1'b0; bus.bready_i = 1'b0;
    bus.araddr_i = '0; bus.arprot_i = '0; bus.arvalid_i = 1'b0; bus.rready_i = 1'b0;
  endtask

  // lead > 0: W handshakes lead cycles before AW; lead < 0: AW first; 0: same cycle.
  task automatic drive_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                             input logic [SW-1:0] strb, input int lead, input int b_hold,
                             input string name);
    int t;
    logic [1:0] eresp;
    eresp = ref_resp(addr);
    t = 0;
    while (!(bus.awready_o && bus.wready_o) && t < TMO) begin cycle(); t++; end
    checks++;
    if (t >= TMO) begin
      failures++;
      $display("FAIL %s_wr_ready_timeout awready=%b wready=%b required 1/1", name, bus.awready_o, bus.wready_o);
    end
    bus.awaddr_i = addr; bus.wdata_i = data; bus.wstrb_i = strb;
    if (lead == 0) begin
      bus.awvalid_i = 1'b1; bus.wvalid_i = 1'b1;
      cycle();
      bus.awvalid_i = 1'b0; bus.wvalid_i = 1'b0;
    end else if (lead > 0) begin
      bus.wvalid_i = 1'b1;
      cycle();
      bus.wvalid_i = 1'b0;
      for (int i = 0; i < lead; i++) begin
        checks++;
        if (bus.wready_o !== 1'b0 || bus.awready_o !== 1'b1 || bus.bvalid_o !== 1'b0) begin
          failures++;
          $display("FAIL %s_w_held wready=%b awready=%b bvalid=%b required 0/1/0", name, bus.wready_o, bus.awready_o, bus.bvalid_o);
        end
        if (i == lead - 1) bus.awvalid_i = 1'b1;
        cycle();
      end
      bus.awvalid_i = 1'b0;
    end else begin
      bus.awvalid_i = 1'b1;
      cycle();
      bus.awvalid_i = 1'b0;
      for (int i = 0; i < -lead; i++) begin
        checks++;
        if (bus.awready_o !== 1'b0 || bus.wready_o !== 1'b1 || bus.bvalid_o !== 1'b0) begin
          failures++;
          $display("FAIL %s_aw_held awready=%b wready=%b bvalid=%b required 0/1/0", name, bus.awready_o, bus.wready_o, bus.bvalid_o);
        end
        if (i == -lead - 1) bus.wvalid_i = 1'b1;
        cycle();
      end
      bus.wvalid_i = 1'b0;
    end
    checks++;
    if (bus.bvalid_o !== 1'b1 || bus.bresp_o !== eresp) begin
      failures++;
      $display("FAIL %s_bresp bvalid=%b bresp=%b required 1/%b", name, bus.bvalid_o, bus.bresp_o, eresp);
    end
    ref_write(addr, data, strb);
    for (int i = 0; i < b_hold; i++) begin
      cycle();
      checks++;
      if (bus.bvalid_o !== 1'b1 || bus.bresp_o !== eresp || bus.awready_o !== 1'b0 || bus.wready_o !== 1'b0) begin
        failures++;
        $display("FAIL %s_b_stall bvalid=%b bresp=%b awready=%b wready=%b required 1/%b/0/0", name, bus.bvalid_o, bus.bresp_o, bus.awready_o, bus.wready_o, eresp);
      end
    end
    bus.bready_i = 1'b1;
    cycle();
    bus.bready_i = 1'b0;
    checks++;
    if (bus.bvalid_o !== 1'b0 || bus.awready_o !== 1'b1 || bus.wready_o !== 1'b1) begin
      failures++;
      $display("FAIL %s_b_done bvalid=%b awready=%b wready=%b required 0/1/1", name, bus.bvalid_o, bus.awready_o, bus.wready_o);
    end
  endtask

  task automatic drive_read(input logic [AW-1:0] addr, input int r_hold, input string name);
    int t;
    logic [DW-1:0] edata, mask, first;
    logic [1:0] eresp;
    exp_q.push_back(ref_data(addr));
    exp_resp_q.push_back(ref_resp(addr));
    mask = ref_mask(addr);
    t = 0;
    while (!bus.arready_o && t < TMO) begin cycle(); t++; end
    checks++;
    if (t >= TMO) begin
      failures++;
      $display("FAIL %s_ar_ready_timeout arready=%b required 1", name, bus.arready_o);
    end
    bus.araddr_i = addr; bus.arvalid_i = 1'b1;
    cycle();
    bus.arvalid_i = 1'b0;
    edata = exp_q.pop_front();
    eresp = exp_resp_q.pop_front();
    first = bus.rdata_o;
    checks++;
    if (bus.rvalid_o !== 1'b1 || bus.arready_o !== 1'b0 || bus.rresp_o !== eresp ||
        (bus.rdata_o & mask) !== (edata & mask)) begin
      failures++;
      $display("FAIL %s_rdata rvalid=%b arready=%b rresp=%b rdata=%h required 1/0/%b/%h (mask %h)", name, bus.rvalid_o, bus.arready_o, bus.rresp_o, bus.rdata_o, eresp, edata, mask);
    end
    for (int i = 0; i < r_hold; i++) begin
      cycle();
      checks++;
      if (bus.rvalid_o !== 1'b1 || bus.rdata_o !== first || bus.rresp_o !== eresp || bus.arready_o !== 1'b0) begin
        failures++;
        $display("FAIL %s_r_stall rvalid=%b rdata=%h rresp=%b arready=%b required 1/%h/%b/0", name, bus.rvalid_o, bus.rdata_o, bus.rresp_o, bus.arready_o, first, eresp);
      end
    end
    bus.rready_i = 1'b1;
    cycle();
    bus.rready_i = 1'b0;
    checks++;
    if (bus.rvalid_o !== 1'b0 || bus.arready_o !== 1'b1) begin
      failures++;
      $display("FAIL %s_r_done rvalid=%b arready=%b required 0/1", name, bus.rvalid_o, bus.arready_o);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) cycle();
    checks++;
    if ({bus.awready_o, bus.wready_o, bus.arready_o, bus.bvalid_o, bus.rvalid_o} !== 5'b11100 ||
        bus.bresp_o !== 2'b00 || bus.rresp_o !== 2'b00 || bus.rdata_o !== '0) begin
      failures++;
      $display("FAIL reset_values rdy/valid=%b bresp=%b rresp=%b rdata=%h required 11100/00/00/0",
               {bus.awready_o, bus.wready_o, bus.arready_o, bus.bvalid_o, bus.rvalid_o}, bus.bresp_o, bus.rresp_o, bus.rdata_o);
    end
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_basic();
    drive_write(28'h8, 64'hDEADBEEF_01234567, 8'hFF, 0, 0, "basic_wr");
    drive_read(28'h8, 0, "basic_rd");
  endtask

  task automatic test_strobes();
    drive_write(28'h10, 64'h11223344_55667788, 8'hFF, 0, 0, "strb_full");
    drive_write(28'h10, 64'hFFFFFFFF_FFFFFFFF, 8'h0F, 3, 0, "strb_lo");
    drive_read(28'h10, 0, "strb_rd");
    drive_write(28'h10, 64'h0, 8'h00, -2, 0, "strb_zero");
    drive_read(28'h10, 0, "strb_zero_rd");
  endtask

  task automatic test_out_of_range();
    drive_write(28'h0, 64'hA5A5A5A5_5A5A5A5A, 8'hFF, 0, 0, "oor_w0");
    drive_write(28'h2000, 64'h12345678_9ABCDEF0, 8'hFF, 0, 0, "oor_wr");
    drive_read(28'h2000, 0, "oor_rd");
    drive_read(28'h0, 0, "oor_w0_rd");
  endtask

  task automatic test_backpressure();
    drive_write(28'h18, 64'h0BAD_F00D_CAFE_BABE, 8'hFF, 0, 5, "bp_wr");
    drive_read(28'h18, 5, "bp_rd");
  endtask

  task automatic test_collision();
    logic [DW-1:0] a_val, b_val;
    a_val = 64'hAAAA_0000_AAAA_0004;
    b_val = 64'hBBBB_1111_BBBB_0004;
    drive_write(28'h20, a_val, 8'hFF, 0, 0, "col_a");
    bus.wdata_i = b_val; bus.wstrb_i = 8'hFF; bus.wvalid_i = 1'b1;
    cycle();
    bus.wvalid_i = 1'b0;
    bus.awaddr_i = 28'h20; bus.awvalid_i = 1'b1;
    bus.araddr_i = 28'h20; bus.arvalid_i = 1'b1;
    cycle();
    bus.awvalid_i = 1'b0; bus.arvalid_i = 1'b0;
    checks++;
    if (bus.rvalid_o !== 1'b1 || bus.rdata_o !== a_val || bus.bvalid_o !== 1'b1 || bus.bresp_o !== 2'b00) begin
      failures++;
      $display("FAIL collision_rbw rvalid=%b rdata=%h bvalid=%b bresp=%b required 1/%h/1/00", bus.rvalid_o, bus.rdata_o, bus.bvalid_o, bus.bresp_o, a_val);
    end
    ref_write(28'h20, b_val, 8'hFF);
    bus.bready_i = 1'b1; bus.rready_i = 1'b1;
    cycle();
    bus.bready_i = 1'b0; bus.rready_i = 1'b0;
    drive_read(28'h20, 0, "collision_after");
  endtask

  task automatic test_back_to_back();
    drive_write(28'h30, 64'h1, 8'hFF, 0, 0, "b2b_w0");
    drive_write(28'h38, 64'h2, 8'hFF, 0, 0, "b2b_w1");
    bus.awaddr_i = 28'h40; bus.wdata_i = 64'h3333_4444_5555_6666; bus.wstrb_i = 8'hFF;
    bus.awvalid_i = 1'b1; bus.wvalid_i = 1'b1;
    bus.araddr_i = 28'h38; bus.arvalid_i = 1'b1;
    cycle();
    bus.awvalid_i = 1'b0; bus.wvalid_i = 1'b0; bus.arvalid_i = 1'b0;
    checks++;
    if (bus.bvalid_o !== 1'b1 || bus.rvalid_o !== 1'b1 || bus.rdata_o !== 64'h2) begin
      failures++;
      $display("FAIL b2b_concurrent bvalid=%b rvalid=%b rdata=%h required 1/1/%h", bus.bvalid_o, bus.rvalid_o, bus.rdata_o, 64'h2);
    end
    ref_write(28'h40, 64'h3333_4444_5555_6666, 8'hFF);
    bus.bready_i = 1'b1; bus.rready_i = 1'b1;
    cycle();
    bus.bready_i = 1'b0; bus.rready_i = 1'b0;
    drive_read(28'h40, 0, "b2b_rd");
  endtask

  task automatic test_reset_mid();
    drive_write(28'hA0, 64'hC0C0_C0C0_1234_5678, 8'hFF, 0, 0, "rst_pre");
    bus.awaddr_i = 28'hA0; bus.awvalid_i = 1'b1;
    bus.araddr_i = 28'h8;  bus.arvalid_i = 1'b1;
    cycle();
    bus.awvalid_i = 1'b0; bus.arvalid_i = 1'b0;
    checks++;
    if (bus.awready_o !== 1'b0 || bus.rvalid_o !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_setup awready=%b rvalid=%b required 0/1", bus.awready_o, bus.rvalid_o);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.awready_o, bus.wready_o, bus.arready_o, bus.bvalid_o, bus.rvalid_o} !== 5'b11100 ||
        bus.bresp_o !== 2'b00 || bus.rresp_o !== 2'b00 || bus.rdata_o !== '0) begin
      failures++;
      $display("FAIL rst_mid_values rdy/valid=%b bresp=%b rresp=%b rdata=%h required 11100/00/00/0",
               {bus.awready_o, bus.wready_o, bus.arready_o, bus.bvalid_o, bus.rvalid_o}, bus.bresp_o, bus.rresp_o, bus.rdata_o);
    end
    cycle();
    rst_n = 1'b1;
    cycle();
    drive_write(28'hA8, 64'h7777_8888_9999_AAAA, 8'hFF, 0, 0, "rst_post_wr");
    drive_read(28'hA0, 0, "rst_discard");
    drive_read(28'hA8, 0, "rst_post_rd");
  endtask

  task automatic test_random();
    logic [AW-1:0] addr;
    int idx;
    for (int n = 0; n < 40; n++) begin
      idx = ($urandom_range(0, 9) == 0) ? 1024 + int'($urandom_range(0, 50)) : int'($urandom_range(0, 15));
      addr = AW'({idx, 3'(($urandom_range(0, 7)))});
      if ($urandom_range(0, 1) == 0) begin
        drive_write(addr, {$urandom, $urandom}, 8'($urandom_range(0, 255)),
                    int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 2)), "rand_wr");
      end else begin
        drive_read(addr, int'($urandom_range(0, 2)), "rand_rd");
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < ELS; i++) begin
      ref_mem[i] = '0;
      ref_known[i] = '0;
    end
    idle_bus();
    test_reset();
    test_basic();
    test_strobes();
    test_out_of_range();
    test_backpressure();
    test_collision();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
